// File: rtl/vpe_lane_collector.sv
// vpe_lane_collector: per-lane FIFOs that realign skewed PE lane
// results into whole phits on a ready/valid egress stream.
module vpe_lane_collector #(
  parameter int DWIDTH    = 32,
  parameter int LANES     = 16,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LANES*DWIDTH-1:0]   i_data,
  input  logic [LANES-1:0]          i_tvalid,
  output logic [LANES*DWIDTH-1:0]   o_tdata,
  output logic                      o_tvalid,
  input  logic                      o_tready,
  output logic                      almost_full,
  output logic [LANES-1:0]          overflow,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic                    ena_q;
  logic [DWIDTH-1:0]       mem_q [LANES][DEPTH];
  logic [PW-1:0]           wptr_q [LANES];
  logic [PW-1:0]           wptr_d [LANES];
  logic [CW-1:0]           cnt_q  [LANES];
  logic [CW-1:0]           cnt_d  [LANES];
  logic [PW-1:0]           rptr_q, rptr_d;
  logic [LANES-1:0]        wr_en;
  logic [LANES-1:0]        ovf_q, ovf_d;
  logic [LANES*DWIDTH-1:0] tdata_q, tdata_d;
  logic                    tvalid_q, tvalid_d;
  logic [CW-1:0]           level_q, level_d;
  logic                    af_q, af_d;
  logic                    pop;

  assign o_tdata     = tdata_q;
  assign o_tvalid    = tvalid_q;
  assign overflow    = ovf_q;
  assign level       = level_q;
  assign almost_full = af_q;

  // Pop all lanes together once every lane has a head and the
  // output register is free or being drained.
  always_comb begin
    pop = 1'b1;
    for (int i = 0; i < LANES; i++)
      if (cnt_q[i] == '0) pop = 1'b0;
    pop = pop && (!tvalid_q || o_tready);
  end

  // Per-lane write acceptance, pointers, counts and flag updates.
  always_comb begin
    wr_en   = '0;
    ovf_d   = ovf_q;
    level_d = '0;
    for (int i = 0; i < LANES; i++) begin
      wr_en[i] = ena_q && i_tvalid[i] &&
                 (cnt_q[i] != CW'(DEPTH) || pop);
      if (ena_q && i_tvalid[i] && !wr_en[i])
        ovf_d[i] = 1'b1;
      wptr_d[i] = wptr_q[i] + {{(PW-1){1'b0}}, wr_en[i]};
      cnt_d[i]  = cnt_q[i] + {{PW{1'b0}}, wr_en[i]}
                           - {{PW{1'b0}}, pop};
      if (cnt_d[i] > level_d) level_d = cnt_d[i];
    end
    af_d   = (level_d >= CW'(AF_THRESH));
    rptr_d = rptr_q + {{(PW-1){1'b0}}, pop};
  end

  // Output register: load heads on pop, clear on drain, else hold.
  always_comb begin
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    if (pop) begin
      tvalid_d = 1'b1;
      for (int i = 0; i < LANES; i++)
        tdata_d[i*DWIDTH +: DWIDTH] = mem_q[i][rptr_q];
    end else if (o_tready) begin
      tvalid_d = 1'b0;
    end
  end

  // Control state with asynchronous clear; ena_q delays write
  // acceptance until one edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ena_q    <= 1'b0;
      rptr_q   <= '0;
      ovf_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      level_q  <= '0;
      af_q     <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        wptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      ena_q    <= 1'b1;
      rptr_q   <= rptr_d;
      ovf_q    <= ovf_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      level_q  <= level_d;
      af_q     <= af_d;
      for (int i = 0; i < LANES; i++) begin
        wptr_q[i] <= wptr_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  // Lane storage; contents are don't-care until counted valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++)
      if (wr_en[i])
        mem_q[i][wptr_q[i]] <= i_data[i*DWIDTH +: DWIDTH];
  end

endmodule

// File: doc/vpe_lane_collector.md
Name: vpe_lane_collector

Overview:
- Output-side counterpart of the vectorized PE array.
- The PE lanes emit results with independent per-lane valid strobes, no backpressure, and possibly skewed timing between lanes.
- This block buffers each lane in a small FIFO, aligns the lanes, and emits whole phits on a ready/valid stream toward the network/egress side.
- It also flags lane overflow and raises an almost-full indication to the issue controller.

Parameters:
- DWIDTH, 32: width of one float lane in bits.
- LANES, 16: SIMD degree, i.e. number of lanes; phit width is LANES*DWIDTH = 512.
- DEPTH, 8: entries per lane FIFO; must be a power of 2 and at least 4.
- AF_THRESH, 6: lane occupancy at or above which almost_full asserts.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_data  in  LANES*DWIDTH  lane results; lane i occupies bits [(i+1)*DWIDTH-1 : i*DWIDTH].
- i_tvalid  in  LANES  per-lane write strobe; no ready is returned.
- o_tdata  out  LANES*DWIDTH  aligned output phit.
- o_tvalid  out  1  output phit valid.
- o_tready  in  1  downstream accept.
- almost_full  out  1  asserted when any lane occupancy is >= AF_THRESH.
- overflow  out  LANES  sticky per-lane overflow flags.
- level  out  $clog2(DEPTH)+1  maximum occupancy across all lanes.

Behaviour:
- Reset (rst low, asynchronous):
  - All FIFO pointers and counts go to 0.
  - o_tvalid=0, o_tdata=0, overflow=0, almost_full=0, level=0.
  - A reset mid-transfer discards all buffered data and the output register.
  - Release of reset is synchronised internally; the first write is accepted on the second rising edge after rst rises.
- Lane FIFO i:
  - Write when i_tvalid[i]=1.
  - Read and write pointers wrap modulo DEPTH. The count ranges 0..DEPTH.
- Pop condition (pop): every lane count is >0 AND (o_tvalid=0 OR o_tready=1).
  - On pop, all lanes pop together in the same cycle.
  - The head of lane i loads into o_tdata lane i, and o_tvalid is set to 1.
- Output register:
  - If o_tvalid=1 and o_tready=0, o_tdata and o_tvalid hold stable (AXI-Stream rule).
  - If o_tvalid=1, o_tready=1 and there is no pop, o_tvalid goes to 0 on the next edge.
  - If o_tvalid=1, o_tready=1 and pop, o_tdata is replaced in the same edge, giving back-to-back phits at 1 phit/cycle.
- Latency: a lane set completed at edge t has pop evaluated in cycle t+1, so o_tvalid is visible after edge t+1. Minimum latency is 2 cycles from i_tvalid to o_tvalid.
- Full lane:
  - A write to lane i with count=DEPTH and no pop that cycle is dropped, and overflow[i] is set.
  - overflow[i] is sticky and is cleared only by reset.
  - A write with count=DEPTH in a pop cycle is accepted, and the count stays DEPTH.
- Simultaneous write and pop on a lane: the count is unchanged and the data ordering is preserved (FIFO).
- Empty lane: no pop while any lane is empty, even if the other lanes are full.
- Skewed lanes: lane data is aligned by arrival order per lane, not by the cycle of arrival.
- level and almost_full:
  - Both are registered from the post-update counts, i.e. they reflect state after the edge.
  - They are combinationally independent of o_tready.
- Lane ordering: o_tdata lane i always originates from i_data lane i; there is no lane permutation.

Test Plan:
1. Aligned stream: i_tvalid=16'hFFFF for 4 cycles with lane i carrying data 32'h100*k+i at cycle k, o_tready=1 -> 4 consecutive o_tvalid cycles starting 2 cycles after the first write; o_tdata lane i = 32'h100*k+i; level returns to 0.
2. Skewed lanes: even lanes write at cycle 0, odd lanes write at cycle 3 -> o_tvalid stays 0 until after the cycle-3 edge plus 1 cycle; a single phit is emitted containing both sets; no overflow.
3. Backpressure: 8 aligned writes with o_tready=0 -> o_tvalid=1 with o_tdata stable for the full stall; the output register holds 1 phit and the lanes hold 7, so level=7 and almost_full=1. A 9th aligned write is accepted (lanes at 8) and overflow stays 0. A 10th write sets overflow=16'hFFFF and its data is dropped. After releasing o_tready, 9 phits emerge in order.
4. Write on a full lane during a pop: fill lane 0 to DEPTH, all other lanes hold 1 entry, o_tready=1, and write lane 0 in the pop cycle -> accepted, overflow[0]=0, lane 0 count stays 8.
5. Asynchronous reset mid-stream: assert rst low while o_tvalid=1 and level=5 -> outputs go to 0 immediately without waiting for clk; after release, fresh data passes with 2-cycle latency and no stale phits appear.
6. Pointer wrap: stream 3*DEPTH aligned phits with o_tready toggling 1,0,1,0 -> all 24 phits are received in order with no loss and no duplication.
